dma_bram_responder: RTL and testbench
=====================================

# dma_bram_responder

Device-side responder for the AFU DMA interface (`dma_if`). It serves read and write transfers from an on-chip simple-dual-port cache-line memory instead of host memory. The block lets the AFU, the memory controller and the CPU core be simulated and run on-board without the host DMA/HAL path. It connects directly to the same `rd_*`/`wr_*`/`empty`/`full` signals the AFU drives and consumes.

## Interface
Parameters:
- `DATA_WIDTH`, 512: cache-line width in bits.
- `ADDR_WIDTH`, 64: virtual byte address width.
- `SIZE_WIDTH`, 43: transfer size width, in cache lines.
- `MEM_LINES_LOG2`, 10: log2 of the number of lines in the backing memory.
- `FIFO_DEPTH`, 4: read prefetch FIFO depth; power of 2, at least 2.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rd_go`  in  1  one-cycle pulse; starts a read transfer.
- `rd_addr`  in  ADDR_WIDTH  starting byte address; sampled with `rd_go`.
- `rd_size`  in  SIZE_WIDTH  number of lines to read; sampled with `rd_go`.
- `rd_en`  in  1  pops the FIFO head; only effective when `empty`=0.
- `rd_data`  out  DATA_WIDTH  FIFO head (first-word fall-through).
- `empty`  out  1  no read data available.
- `rd_done`  out  1  all `rd_size` lines have been popped.
- `wr_go`  in  1  one-cycle pulse; starts a write transfer.
- `wr_addr`  in  ADDR_WIDTH  starting byte address; sampled with `wr_go`.
- `wr_size`  in  SIZE_WIDTH  number of lines to write; sampled with `wr_go`.
- `wr_en`  in  1  writes `wr_data`; only effective when `full`=0.
- `wr_data`  in  DATA_WIDTH  write line.
- `full`  out  1  write not accepted this cycle.
- `wr_done`  out  1  all `wr_size` lines have been committed.
- `host_wr_completed`  out  1  one-cycle pulse on the edge that commits the last write line.

## Operation
- Line index = `addr[6 +: MEM_LINES_LOG2]`. Bits [5:0] and upper bits are ignored. Line indices increment per line and wrap modulo 2^MEM_LINES_LOG2.
- Read FSM states are `RD_IDLE`, `RD_RUN` and `RD_DONE`.
  - `rd_go` in any state latches base and size, flushes the FIFO, clears the counters, clears `rd_done`, and enters `RD_RUN`.
  - `rd_go` together with `rd_en` in the same cycle: `rd_go` wins and the pop is discarded.
- `RD_RUN` behaviour:
  - A memory read is issued in any cycle where `issued < size` and `fifo_count + in_flight < FIFO_DEPTH`.
  - Memory read latency is 1 cycle; the returned line is pushed into the FIFO.
  - A pop on `rd_en & ~empty` increments `popped`.
  - When `popped == size`, the FSM enters `RD_DONE`.
- `RD_DONE` holds `rd_done`=1 until the next `rd_go` or reset.
- Write FSM states are `WR_IDLE`, `WR_RUN` and `WR_DONE`.
  - `wr_go` latches base and size, clears `written` and `wr_done`, and enters `WR_RUN`.
  - `full`=0 only in `WR_RUN` while `written < size`.
  - `wr_en & ~full` writes `wr_data` to line `base + written` and increments `written`.
  - The last accepted write moves the FSM to `WR_DONE` and pulses `host_wr_completed`.
  - `wr_en` while `full`=1 is ignored: no memory write and no count change.
- Size 0 on either channel: go to the DONE state on the edge after go; no memory access.
- Read and write channels run concurrently and independently.
- Same-line read and write in the same cycle: the read returns the old data.
- Counters are SIZE_WIDTH bits wide; comparisons are unsigned.

## Timing
- Reset values: `empty`=1, `full`=1, `rd_done`=0, `wr_done`=0, `host_wr_completed`=0, `rd_data`=0; FSMs in `RD_IDLE`/`WR_IDLE`. Memory contents are not reset.
- Read latency:
  - `rd_go` is sampled at edge E0.
  - The first read is issued in the cycle after E0.
  - `empty` falls after E2, i.e. data is visible 2 cycles after the `rd_go` cycle.
- Sustained read throughput is 1 line/cycle when `rd_en` is held high.
- `rd_done` rises on the edge that performs the final pop.
- Write timing:
  - `full` falls on the edge that samples `wr_go`.
  - A write takes effect on the edge where `wr_en & ~full` is sampled.
  - `full` rises and `wr_done` rises on that same edge for the final line.
  - `host_wr_completed` is high for exactly the cycle after that edge.
- Reset mid-transfer aborts both channels and returns all outputs to their reset values on the next edge.

## Test plan
- Backdoor-preload lines 0..3 with 0xA0..0xA3. Pulse `rd_go` (addr 0x0, size 4) with `rd_en` held high → `empty` falls 2 cycles later; 0xA0..0xA3 arrive on consecutive cycles; `rd_done`=1 after the 4th pop.
- `wr_go` (addr 0x80, size 3) followed by writes of 0x11, 0x22, 0x33 → `full`=1, `wr_done`=1, and a single `host_wr_completed` pulse. A subsequent read of addr 0x80, size 3 returns 0x11, 0x22, 0x33.
- Read of size 8 with `rd_en` low → FIFO fills to 4 and issuing stalls. Then pop one line every 3 cycles → 8 lines come out in order with no duplicates or drops.
- Write at line 2^MEM_LINES_LOG2−1, size 2 → the second line lands at line 0 (wrap), confirmed by read-back.
- `rd_go` issued while a read is mid-transfer, with `rd_en`=1 in the same cycle → FIFO is flushed, the new base's data is returned, and `rd_done` reflects only the new size.
- Size 0 on both channels → `rd_done`/`wr_done` assert one edge after go; `empty` stays 1; no memory write occurs. Assert `rst_n`=0 mid-write → `full`=1 and `wr_done`=0 on the next edge.

Source files
------------

// File: rtl/dma_bram_responder.sv
// Device-side DMA responder: serves AFU read/write line transfers from an
// on-chip simple-dual-port line memory, with a first-word fall-through read FIFO.
module dma_bram_responder #(
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned SIZE_WIDTH     = 43,
    parameter int unsigned MEM_LINES_LOG2 = 10,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_go,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [SIZE_WIDTH-1:0] rd_size,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  rd_done,
    input  logic                  wr_go,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [SIZE_WIDTH-1:0] wr_size,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  wr_done,
    output logic                  host_wr_completed
);

    localparam int unsigned MEM_LINES = 1 << MEM_LINES_LOG2;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DONE} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_RUN, WR_DONE} wr_state_t;

    // Backing line memory
    logic [DATA_WIDTH-1:0]     mem [MEM_LINES];
    logic [DATA_WIDTH-1:0]     mem_rd_q;
    logic                      mem_rd_en;
    logic                      mem_wr_en;
    logic [MEM_LINES_LOG2-1:0] mem_rd_line;
    logic [MEM_LINES_LOG2-1:0] mem_wr_line;

    always_ff @(posedge clk) begin
        if (mem_wr_en)
            mem[mem_wr_line] <= wr_data;
        if (mem_rd_en)
            mem_rd_q <= mem[mem_rd_line];
    end

    // Read channel
    rd_state_t                 rd_state, rd_state_nxt;
    logic [MEM_LINES_LOG2-1:0] rd_base;
    logic [SIZE_WIDTH-1:0]     rd_size_q;
    logic [SIZE_WIDTH-1:0]     rd_issued;
    logic [SIZE_WIDTH-1:0]     rd_popped;
    logic [SIZE_WIDTH-1:0]     rd_popped_nxt;
    logic                      rd_pend;
    logic                      rd_pop;
    logic [DATA_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          fifo_wp, fifo_rp;
    logic [CNT_W-1:0]          fifo_count;
    logic [CNT_W:0]            rd_occ;

    assign empty         = (fifo_count == '0);
    assign rd_data       = empty ? '0 : fifo_mem[fifo_rp];
    assign rd_done       = (rd_state == RD_DONE);
    assign rd_pop        = rd_en && !empty && !rd_go;
    assign rd_popped_nxt = rd_popped + SIZE_WIDTH'(rd_pop);
    // The line in flight counts against FIFO space so a push can never overflow.
    assign rd_occ        = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pend};
    assign mem_rd_en     = (rd_state == RD_RUN) && !rd_go &&
                           (rd_issued < rd_size_q) && (rd_occ < DEPTH_OCC);
    assign mem_rd_line   = rd_base + rd_issued[MEM_LINES_LOG2-1:0];

    always_comb begin
        rd_state_nxt = rd_state;
        if (rd_go)
            rd_state_nxt = RD_RUN;
        else if (rd_state == RD_RUN && rd_popped_nxt == rd_size_q)
            rd_state_nxt = RD_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state   <= RD_IDLE;
            rd_base    <= '0;
            rd_size_q  <= '0;
            rd_issued  <= '0;
            rd_popped  <= '0;
            rd_pend    <= 1'b0;
            fifo_wp    <= '0;
            fifo_rp    <= '0;
            fifo_count <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            if (rd_go) begin
                rd_base    <= rd_addr[6 +: MEM_LINES_LOG2];
                rd_size_q  <= rd_size;
                rd_issued  <= '0;
                rd_popped  <= '0;
                rd_pend    <= 1'b0;
                fifo_wp    <= '0;
                fifo_rp    <= '0;
                fifo_count <= '0;
            end else begin
                rd_pend   <= mem_rd_en;
                rd_popped <= rd_popped_nxt;
                if (mem_rd_en)
                    rd_issued <= rd_issued + 1'b1;
                if (rd_pend)
                    fifo_wp <= fifo_wp + 1'b1;
                if (rd_pop)
                    fifo_rp <= fifo_rp + 1'b1;
                fifo_count <= fifo_count + CNT_W'(rd_pend) - CNT_W'(rd_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_pend && !rd_go)
            fifo_mem[fifo_wp] <= mem_rd_q;
    end

    // Write channel
    wr_state_t                 wr_state, wr_state_nxt;
    logic [MEM_LINES_LOG2-1:0] wr_base;
    logic [SIZE_WIDTH-1:0]     wr_size_q;
    logic [SIZE_WIDTH-1:0]     wr_written;
    logic [SIZE_WIDTH-1:0]     wr_written_nxt;
    logic                      wr_accept;

    assign full           = !((wr_state == WR_RUN) && (wr_written < wr_size_q));
    assign wr_done        = (wr_state == WR_DONE);
    assign wr_accept      = rst_n && wr_en && !full && !wr_go;
    assign wr_written_nxt = wr_written + SIZE_WIDTH'(wr_accept);
    assign mem_wr_en      = wr_accept;
    assign mem_wr_line    = wr_base + wr_written[MEM_LINES_LOG2-1:0];

    always_comb begin
        wr_state_nxt = wr_state;
        if (wr_go)
            wr_state_nxt = WR_RUN;
        else if (wr_state == WR_RUN && wr_written_nxt == wr_size_q)
            wr_state_nxt = WR_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state          <= WR_IDLE;
            wr_base           <= '0;
            wr_size_q         <= '0;
            wr_written        <= '0;
            host_wr_completed <= 1'b0;
        end else begin
            wr_state          <= wr_state_nxt;
            host_wr_completed <= wr_accept && (wr_written_nxt == wr_size_q);
            if (wr_go) begin
                wr_base    <= wr_addr[6 +: MEM_LINES_LOG2];
                wr_size_q  <= wr_size;
                wr_written <= '0;
            end else begin
                wr_written <= wr_written_nxt;
            end
        end
    end

    // Only the line-index field of the byte addresses is meaningful.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr[5:0], rd_addr[ADDR_WIDTH-1:6+MEM_LINES_LOG2],
                                wr_addr[5:0], wr_addr[ADDR_WIDTH-1:6+MEM_LINES_LOG2]};

endmodule

// File: tb/tb_dma_bram_responder.sv
// Self-checking bench for dma_bram_responder: directed scenarios plus randomized
// transfers checked against a line-array model of the backing memory.
module tb_dma_bram_responder;

    localparam int unsigned DW    = 512;
    localparam int unsigned AW    = 64;
    localparam int unsigned SW    = 43;
    localparam int unsigned ML2   = 10;
    localparam int unsigned FD    = 4;
    localparam int unsigned LINES = 1 << ML2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_go, rd_en, empty, rd_done;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_size;
    logic [DW-1:0] rd_data;
    logic          wr_go, wr_en, full, wr_done, host_wr_completed;
    logic [AW-1:0] wr_addr;
    logic [SW-1:0] wr_size;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    dma_bram_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
        .MEM_LINES_LOG2(ML2), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_go(rd_go), .rd_addr(rd_addr), .rd_size(rd_size), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
        .wr_go(wr_go), .wr_addr(wr_addr), .wr_size(wr_size), .wr_en(wr_en),
        .wr_data(wr_data), .full(full), .wr_done(wr_done),
        .host_wr_completed(host_wr_completed)
    );

    logic [DW-1:0] model_mem [LINES];
    logic [DW-1:0] wdata_q [$];
    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] actual,
                         input logic [DW-1:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int unsigned i = 0; i < DW / 32; i++)
            v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int unsigned line_of(input logic [AW-1:0] a);
        return 32'((a >> 6) & 64'(LINES - 1));
    endfunction

    // Write transfer; data comes from wdata_q when populated, otherwise random.
    task automatic wr_xfer(input logic [AW-1:0] addr, input int unsigned n,
                           input int unsigned max_gap);
        int unsigned   base;
        int unsigned   k;
        logic [DW-1:0] d;
        base    = line_of(addr);
        k       = 0;
        wr_addr = addr;
        wr_size = SW'(n);
        wr_go   = 1'b1;
        step();
        wr_go = 1'b0;
        check("wr_full_after_go", DW'(full), DW'(n == 0));
        check("wr_done_after_go", DW'(wr_done), '0);
        while (k < n) begin
            wr_en = 1'b0;
            if (max_gap > 0)
                repeat ($urandom_range(max_gap, 0)) step();
            d = (wdata_q.size() > 0) ? wdata_q.pop_front() : rand_line();
            wr_en   = 1'b1;
            wr_data = d;
            step();
            wr_en = 1'b0;
            model_mem[(base + k) % LINES] = d;
            k++;
            check("wr_full", DW'(full), DW'(k == n));
            check("wr_done", DW'(wr_done), DW'(k == n));
            check("wr_hwc", DW'(host_wr_completed), DW'(k == n));
        end
        // Writes attempted while full must be dropped; the read-back exposes any leak.
        wr_en   = 1'b1;
        wr_data = rand_line();
        step();
        check("wr_done_hold", DW'(wr_done), DW'(1));
        check("wr_full_hold", DW'(full), DW'(1));
        check("wr_hwc_single", DW'(host_wr_completed), '0);
        step();
        wr_en = 1'b0;
        check("wr_hwc_idle", DW'(host_wr_completed), '0);
    endtask

    // mode 0: rd_en held high, 1: pop every third cycle after a fill wait, 2: random rd_en.
    task automatic rd_xfer(input logic [AW-1:0] addr, input int unsigned n,
                           input int unsigned mode, input int unsigned abort_after);
        int unsigned base;
        int unsigned popped;
        int unsigned cyc;
        bit          seen;
        bit          pop;
        base    = line_of(addr);
        popped  = 0;
        cyc     = 0;
        seen    = 1'b0;
        rd_addr = addr;
        rd_size = SW'(n);
        rd_go   = 1'b1;
        rd_en   = (mode == 0);
        step();
        rd_go = 1'b0;
        check("rd_empty_after_go", DW'(empty), DW'(1));
        check("rd_done_after_go", DW'(rd_done), '0);
        while (popped < n && cyc < 300 && !(abort_after != 0 && popped == abort_after)) begin
            case (mode)
                0:       rd_en = 1'b1;
                1:       rd_en = (cyc >= 12) && (cyc % 3 == 0);
                default: rd_en = 1'($urandom_range(1, 0));
            endcase
            if (!empty && !seen) begin
                seen = 1'b1;
                check("rd_first_latency", DW'(cyc), DW'(2));
            end
            pop = rd_en && !empty;
            if (pop)
                check("rd_data", rd_data, model_mem[(base + popped) % LINES]);
            step();
            cyc++;
            if (pop) begin
                popped++;
                check("rd_done", DW'(rd_done), DW'(popped == n));
            end
        end
        if (abort_after != 0 && popped == abort_after)
            return;
        check("rd_pop_count", DW'(popped), DW'(n));
        if (mode == 0 && n > 0)
            check("rd_throughput", DW'(cyc), DW'(n + 2));
        rd_en = 1'b1;
        step();
        check("rd_done_hold", DW'(rd_done), DW'(1));
        check("rd_empty_end", DW'(empty), DW'(1));
        step();
        check("rd_no_extra", DW'(empty), DW'(1));
        check("rd_data_idle", rd_data, '0);
        rd_en = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        int unsigned   n;
        rst_n   = 1'b0;
        rd_go   = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_size = '0;
        wr_go   = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_size = '0; wr_data = '0;
        repeat (3) step();
        check("rst_empty", DW'(empty), DW'(1));
        check("rst_full", DW'(full), DW'(1));
        check("rst_rd_done", DW'(rd_done), '0);
        check("rst_wr_done", DW'(wr_done), '0);
        check("rst_hwc", DW'(host_wr_completed), '0);
        check("rst_rd_data", rd_data, '0);
        rst_n = 1'b1;
        step();

        // Lines 0..3 = A0..A3, streamed back with rd_en held high
        for (int unsigned i = 0; i < 4; i++) wdata_q.push_back(DW'(8'hA0 + i));
        wr_xfer(64'h0, 4, 0);
        rd_xfer(64'h0, 4, 0, 0);

        for (int unsigned i = 1; i <= 3; i++) wdata_q.push_back(DW'(8'h11 * i));
        wr_xfer(64'h80, 3, 0);
        rd_xfer(64'h80, 3, 0, 0);

        // Slow consumer: FIFO fills and issuing must stall without loss
        wr_xfer(64'h1000, 8, 1);
        rd_xfer(64'h1000, 8, 1, 0);

        // Wrap from the last line to line 0, with stray low and high address bits
        wr_xfer({16'hBEEF, 32'h0, 16'(LINES - 1) << 6} | 64'h15, 2, 1);
        rd_xfer(64'(LINES - 1) << 6, 2, 2, 0);
        rd_xfer(64'h0, 1, 0, 0);

        // Restart a read mid-transfer with a coincident pop
        wr_xfer(64'h2000, 6, 0);
        wr_xfer(64'h3000, 3, 0);
        rd_xfer(64'h2000, 6, 0, 2);
        rd_xfer(64'h3000, 3, 0, 0);

        // Zero-size transfers; line 1 must survive the dropped writes
        wr_xfer(64'h40, 0, 0);
        rd_xfer(64'h40, 0, 0, 0);
        rd_xfer(64'h40, 1, 0, 0);

        for (int unsigned t = 0; t < 8; t++) begin
            a = {$urandom, $urandom};
            n = $urandom_range(12, 1);
            wr_xfer(a, n, 2);
            rd_xfer(a, n, $urandom_range(2, 0), 0);
        end

        // Reset in the middle of a write with a read also in progress
        rd_addr = 64'h1000; rd_size = SW'(8); rd_go = 1'b1;
        wr_addr = 64'h5000; wr_size = SW'(5); wr_go = 1'b1;
        step();
        rd_go = 1'b0; wr_go = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            wr_en   = 1'b1;
            wr_data = rand_line();
            model_mem[(line_of(64'h5000) + i) % LINES] = wr_data;
            step();
        end
        wr_en = 1'b0;
        step();
        check("mid_full", DW'(full), '0);
        check("mid_empty", DW'(empty), '0);
        rst_n = 1'b0;
        step();
        check("abort_full", DW'(full), DW'(1));
        check("abort_wr_done", DW'(wr_done), '0);
        check("abort_hwc", DW'(host_wr_completed), '0);
        check("abort_empty", DW'(empty), DW'(1));
        check("abort_rd_done", DW'(rd_done), '0);
        check("abort_rd_data", rd_data, '0);
        rst_n = 1'b1;
        step();
        rd_xfer(64'h5000, 2, 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
